// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// It predicts taken/target for the IF-stage PC in the same cycle and is
// trained by the branch resolution from the ID stage. It also flags
// mispredictions, supplies the redirect PC and keeps saturating branch and
// mispredict statistics.
module branch_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int          STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_f,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // BTB storage, one element per entry field.
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];

  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mp;

  // Lookup side (IF stage).
  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic              w_f_hit;
  logic [ADDR_W-1:0] w_f_seq_pc;

  // Update side (ID stage resolution).
  logic [IDX_W-1:0]  w_u_idx;
  logic [TAG_W-1:0]  w_u_tag;
  logic              w_u_hit;
  logic [1:0]        w_u_ctr;
  logic [1:0]        w_ctr_next;
  logic              w_dir_wrong;
  logic              w_tgt_wrong;
  logic [ADDR_W-1:0] w_u_seq_pc;

  assign w_f_idx    = pc_f[IDX_W-1:0];
  assign w_f_tag    = pc_f[ADDR_W-1:IDX_W];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_seq_pc = pc_f + ADDR_W'(1);

  // Prediction is a pure read of the current table contents, so a same-cycle
  // update to the same index is only seen from the next cycle on.
  assign pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
  assign pred_target = pred_taken ? r_target[w_f_idx] : w_f_seq_pc;

  assign w_u_idx    = upd_pc[IDX_W-1:0];
  assign w_u_tag    = upd_pc[ADDR_W-1:IDX_W];
  assign w_u_hit    = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_ctr    = r_ctr[w_u_idx];
  assign w_u_seq_pc = upd_pc + ADDR_W'(1);

  // Saturating 2-bit counter step toward the resolved direction.
  always_comb begin
    // NOTE: default first so every path assigns w_ctr_next and no latch is inferred.
    w_ctr_next = w_u_ctr;
    if (upd_taken) begin
      if (w_u_ctr != CTR_STRONG_T) w_ctr_next = w_u_ctr + 2'd1;
    end else begin
      if (w_u_ctr != CTR_STRONG_NT) w_ctr_next = w_u_ctr - 2'd1;
    end
  end

  // A wrong direction always mispredicts; a correct taken prediction still
  // mispredicts when the carried target differs from the resolved one.
  assign w_dir_wrong = (upd_pred_taken != upd_taken);
  assign w_tgt_wrong = upd_taken && upd_pred_taken && (upd_pred_target != upd_target);
  assign mispredict  = upd_valid && (w_dir_wrong || w_tgt_wrong);

  assign redirect_pc = !upd_valid ? '0 :
                       (upd_taken ? upd_target : w_u_seq_pc);

  // Table training: update counters on a hit, allocate only taken misses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the table is cleared on reset because stale valid bits or counters
      // would otherwise leak pre-reset history into predictions.
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_INIT;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        // NOTE: non-blocking writes keep this edge's reads on the old entry.
        r_ctr[w_u_idx] <= w_ctr_next;
        if (upd_taken) r_target[w_u_idx] <= upd_target;
      end else if (upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_ctr[w_u_idx]    <= CTR_WEAK_T;
      end
    end
  end

  // Statistics: count resolved branches and mispredicts, holding at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid) begin
      if (!(&r_stat_br)) r_stat_br <= r_stat_br + STAT_W'(1);
      if (mispredict && !(&r_stat_mp)) r_stat_mp <= r_stat_mp + STAT_W'(1);
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the BTB.
module tb_branch_predictor;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int STAT_W  = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] pc_f;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_INIT(2'b01), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot remembers which full PC owns it; a lookup hits only when that
  // exact PC asks again (same index and same upper bits).
  bit          m_ready = 1'b0;
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_branches;
  int          m_mispredicts;

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'(pc % ENTRIES);
    return m_valid[i] && (m_owner[i] == pc);
  endfunction

  function automatic bit m_mispredict();
    if (!upd_valid) return 1'b0;
    if (upd_pred_taken != upd_taken) return 1'b1;
    return upd_taken && (upd_pred_target != upd_target);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_branches    = 0;
      m_mispredicts = 0;
      m_ready       = 1'b1;
    end else if (upd_valid && m_ready) begin
      int i = int'(upd_pc % ENTRIES);
      m_branches++;
      if (m_mispredict()) m_mispredicts++;
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_owner[i] = upd_pc;
        m_tgt[i]   = upd_target;
        m_ctr[i]   = 2;
      end
    end
  end

  // Per-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      int          i;
      bit          e_taken;
      logic [31:0] e_target;
      logic [31:0] e_redirect;
      i        = int'(pc_f % ENTRIES);
      e_taken  = m_hit(pc_f) && (m_ctr[i] >= 2);
      e_target = e_taken ? m_tgt[i] : pc_f + 32'd1;
      e_redirect = !upd_valid ? 32'd0 : (upd_taken ? upd_target : upd_pc + 32'd1);
      check("model pred_taken", 32'(pred_taken), 32'(e_taken));
      check("model pred_target", pred_target, e_target);
      check("model mispredict", 32'(mispredict), 32'(m_mispredict()));
      check("model redirect_pc", redirect_pc, e_redirect);
      check("model stat_branches", 32'(stat_branches),
            32'((m_branches > STAT_MAX) ? STAT_MAX : m_branches));
      check("model stat_mispredicts", 32'(stat_mispredicts),
            32'((m_mispredicts > STAT_MAX) ? STAT_MAX : m_mispredicts));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // One clocked update at 0x40 with the given direction, prediction carried correctly.
  task automatic train40(input logic tk);
    drive(1'b1, 32'h40, tk, 32'h10, tk, 32'h10);
    tick();
    idle();
  endtask

  task automatic look(input logic [31:0] pc, input logic e_tk, input logic [31:0] e_tgt,
                      input string tag);
    pc_f = pc;
    #1;
    check({tag, " pred_taken"}, 32'(pred_taken), 32'(e_tk));
    check({tag, " pred_target"}, pred_target, e_tgt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst  = 1'b0;
    pc_f = 32'h40;
    idle();
    tick();
    tick();
    rst = 1'b1;

    // Reset state.
    look(32'h40, 1'b0, 32'h41, "reset");
    check("reset stat_branches", 32'(stat_branches), 32'd0);
    check("reset stat_mispredicts", 32'(stat_mispredicts), 32'd0);

    // First taken update: predicted not-taken, so it mispredicts.
    drive(1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h41);
    check("first upd mispredict", 32'(mispredict), 32'd1);
    check("first upd redirect", redirect_pc, 32'h10);
    tick();
    idle();
    look(32'h40, 1'b1, 32'h10, "after alloc");
    check("after alloc stat_branches", 32'(stat_branches), 32'd1);
    check("after alloc stat_mispredicts", 32'(stat_mispredicts), 32'd1);

    // Saturation: 10 -> 11 (x3 saturates), then down to 01, 00, 00.
    repeat (3) train40(1'b1);
    look(32'h40, 1'b1, 32'h10, "ctr 11");
    repeat (2) train40(1'b0);
    look(32'h40, 1'b0, 32'h41, "ctr 01");
    repeat (2) train40(1'b0);
    look(32'h40, 1'b0, 32'h41, "ctr 00");
    // From a held 00 one taken step lands on 01 (still not-taken), a second on 10.
    train40(1'b1);
    look(32'h40, 1'b0, 32'h41, "ctr 00->01");
    train40(1'b1);
    look(32'h40, 1'b1, 32'h10, "ctr 01->10");

    // Tag aliasing at index 0.
    look(32'h50, 1'b0, 32'h51, "alias miss");
    drive(1'b1, 32'h50, 1'b1, 32'h99, 1'b0, 32'h51);
    tick();
    idle();
    look(32'h50, 1'b1, 32'h99, "alias owner");
    look(32'h40, 1'b0, 32'h41, "alias evicted");

    // Same-cycle lookup and update: old contents until the edge.
    drive(1'b1, 32'h40, 1'b1, 32'h22, 1'b0, 32'h41);
    tick();
    idle();
    look(32'h40, 1'b1, 32'h22, "realloc");
    drive(1'b1, 32'h40, 1'b1, 32'h33, 1'b1, 32'h22);
    look(32'h40, 1'b1, 32'h22, "collision old");
    check("wrong target mispredict", 32'(mispredict), 32'd1);
    check("wrong target redirect", redirect_pc, 32'h33);
    tick();
    idle();
    look(32'h40, 1'b1, 32'h33, "collision new");

    // Wrap at all-ones and idle combinational outputs.
    look(32'hFFFF_FFFF, 1'b0, 32'h0, "wrap pred");
    check("idle mispredict", 32'(mispredict), 32'd0);
    check("idle redirect", redirect_pc, 32'd0);
    drive(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h5, 1'b0, 32'h0);
    check("nt redirect wrap", redirect_pc, 32'h0);
    check("nt correct mispredict", 32'(mispredict), 32'd0);
    tick();
    idle();
    look(32'hFFFF_FFFF, 1'b0, 32'h0, "nt no alloc");

    // Statistics saturation: 20 mispredicted not-taken updates at a cold PC.
    drive(1'b1, 32'h7, 1'b0, 32'h0, 1'b1, 32'h70);
    repeat (20) tick();
    check("sat stat_branches", 32'(stat_branches), 32'd15);
    check("sat stat_mispredicts", 32'(stat_mispredicts), 32'd15);

    // Reset mid-stream: the update in the reset cycle is not counted.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    check("post-reset stat_branches", 32'(stat_branches), 32'd0);
    check("post-reset stat_mispredicts", 32'(stat_mispredicts), 32'd0);
    look(32'h40, 1'b0, 32'h41, "post-reset history");
    drive(1'b1, 32'h7, 1'b0, 32'h0, 1'b1, 32'h70);
    tick();
    idle();
    check("restart stat_branches", 32'(stat_branches), 32'd1);
    check("restart stat_mispredicts", 32'(stat_mispredicts), 32'd1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
